// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wb_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 2;

  // Which producer drives the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_HOLD = 2'd3
  } wb_src_e;

  // Occupancy of the one-entry ALU hold buffer.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_HELD  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding register for an ALU result that lost arbitration to a load.
// Latency: captured value visible on hold_sel/hold_data the cycle after capture.
// Backpressure: owner must not assert capture while held=1; drain empties it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears the entry)
//   capture             load in_sel/in_data, go HELD (ignored while HELD)
//   drain               release the entry, go EMPTY (ignored while EMPTY)
//   in_sel, in_data     ALU result to park
//   held                entry occupied
//   hold_sel, hold_data parked result
module wb_hold_buf
  import wb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic                  drain,
  input  logic [REG_ADDR_W-1:0] in_sel,
  input  logic [XLEN-1:0]       in_data,
  output logic                  held,
  output logic [REG_ADDR_W-1:0] hold_sel,
  output logic [XLEN-1:0]       hold_data
);

  hold_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] sel_q, sel_d;
  logic [XLEN-1:0]       data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD_EMPTY;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      HOLD_EMPTY: begin
        if (capture) begin
          state_d = HOLD_HELD;
          sel_d   = in_sel;
          data_d  = in_data;
        end
      end
      HOLD_HELD: begin
        if (drain) begin
          state_d = HOLD_EMPTY;
        end
      end
      default: state_d = HOLD_EMPTY;
    endcase
  end

  assign held      = (state_q == HOLD_HELD);
  assign hold_sel  = sel_q;
  assign hold_data = data_q;

endmodule

// File: rtl/writeback_stage.sv
// Arbitrates load and ALU results onto the single register-file write port.
// Latency: 1 cycle from transfer (or hold drain decision) to writeEn/writeSel/writeData.
// Backpressure: memReady tied high; aluReady drops for one entry while an ALU result is parked.
//
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   memValid/memReady/memSel/memData       load result handshake (never stalled)
//   aluValid/aluReady/aluSel/aluData       ALU result handshake (aluReady = !busy)
//   writeEn/writeSel/writeData             registered register-file write port
//   writeCount                             committed writes since reset, wraps at 2^32
//   busy                                   ALU hold buffer occupied
//   fwdValid/fwdSel/fwdData                next-cycle write for decode bypass
//                                          (present only when WB_FORWARD_EN is defined)
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN             = XLEN_DEFAULT,
  parameter int REG_ADDR_W       = REG_ADDR_W_DEFAULT,
  parameter bit ZERO_REG_DISCARD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [REG_ADDR_W-1:0] memSel,
  input  logic [XLEN-1:0]       memData,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [REG_ADDR_W-1:0] aluSel,
  input  logic [XLEN-1:0]       aluData,
  output logic                  writeEn,
  output logic [REG_ADDR_W-1:0] writeSel,
  output logic [XLEN-1:0]       writeData,
  output logic [31:0]           writeCount,
`ifdef WB_FORWARD_EN
  output logic                  fwdValid,
  output logic [REG_ADDR_W-1:0] fwdSel,
  output logic [XLEN-1:0]       fwdData,
`endif
  output logic                  busy
);

  logic                  held;
  logic [REG_ADDR_W-1:0] hold_sel;
  logic [XLEN-1:0]       hold_data;
  logic                  capture, drain;
  logic                  mem_xfer, alu_xfer;
  wb_src_e               src;
  logic [REG_ADDR_W-1:0] pick_sel;
  logic [XLEN-1:0]       pick_data;
  logic                  issue;

  logic                  write_en_q, write_en_d;
  logic [REG_ADDR_W-1:0] write_sel_q, write_sel_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic [31:0]           count_q, count_d;

  assign memReady = 1'b1;
  assign aluReady = !held;
  assign mem_xfer = memValid;
  assign alu_xfer = aluValid && !held;

  // Loads always win: a simultaneous ALU result is the younger instruction,
  // so it is parked and written after the load, even to the same register.
  always_comb begin
    src     = SRC_NONE;
    capture = 1'b0;
    drain   = 1'b0;
    if (held) begin
      if (mem_xfer) begin
        src = SRC_MEM;
      end else begin
        src   = SRC_HOLD;
        drain = 1'b1;
      end
    end else begin
      if (mem_xfer) begin
        src     = SRC_MEM;
        capture = alu_xfer;
      end else if (alu_xfer) begin
        src = SRC_ALU;
      end
    end
  end

  always_comb begin
    pick_sel  = '0;
    pick_data = '0;
    case (src)
      SRC_MEM:  begin pick_sel = memSel;   pick_data = memData;   end
      SRC_ALU:  begin pick_sel = aluSel;   pick_data = aluData;   end
      SRC_HOLD: begin pick_sel = hold_sel; pick_data = hold_data; end
      default:  begin pick_sel = '0;       pick_data = '0;        end
    endcase
  end

  // Register-0 results are still consumed; only the write itself is dropped.
  assign issue = (src != SRC_NONE) && !(ZERO_REG_DISCARD && (pick_sel == '0));

  always_comb begin
    write_en_d   = issue;
    write_sel_d  = write_sel_q;
    write_data_d = write_data_q;
    count_d      = count_q;
    if (issue) begin
      write_sel_d  = pick_sel;
      write_data_d = pick_data;
      count_d      = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_sel_q  <= '0;
      write_data_q <= '0;
      count_q      <= '0;
    end else begin
      write_en_q   <= write_en_d;
      write_sel_q  <= write_sel_d;
      write_data_q <= write_data_d;
      count_q      <= count_d;
    end
  end

  wb_hold_buf #(
    .XLEN      (XLEN),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .drain    (drain),
    .in_sel   (aluSel),
    .in_data  (aluData),
    .held     (held),
    .hold_sel (hold_sel),
    .hold_data(hold_data)
  );

  assign writeEn    = write_en_q;
  assign writeSel   = write_sel_q;
  assign writeData  = write_data_q;
  assign writeCount = count_q;
  assign busy       = held;

`ifdef WB_FORWARD_EN
  assign fwdValid = issue;
  assign fwdSel   = pick_sel;
  assign fwdData  = pick_data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed scenarios followed by random traffic.
// Latency: expected writes are queued at the transfer edge and checked after it.
// Backpressure: ALU stimulus is held stable while aluReady is low.
module tb_writeback_stage;

  localparam int XLEN = 32;
  localparam int RW   = 2;

  typedef struct {
    logic [RW-1:0]   sel;
    logic [XLEN-1:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            memValid = 1'b0;
  logic            memReady;
  logic [RW-1:0]   memSel = '0;
  logic [XLEN-1:0] memData = '0;
  logic            aluValid = 1'b0;
  logic            aluReady;
  logic [RW-1:0]   aluSel = '0;
  logic [XLEN-1:0] aluData = '0;
  logic            writeEn;
  logic [RW-1:0]   writeSel;
  logic [XLEN-1:0] writeData;
  logic [31:0]     writeCount;
  logic            busy;
`ifdef WB_FORWARD_EN
  logic            fwdValid;
  logic [RW-1:0]   fwdSel;
  logic [XLEN-1:0] fwdData;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  wr_t         exp_q[$];   // writes the model says must appear, in order
  wr_t         pend_q[$];  // ALU results accepted but not yet written
  int unsigned exp_count = 0;

  always #5 clk = ~clk;

  writeback_stage #(
    .XLEN(XLEN), .REG_ADDR_W(RW), .ZERO_REG_DISCARD(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .memValid(memValid), .memReady(memReady), .memSel(memSel), .memData(memData),
    .aluValid(aluValid), .aluReady(aluReady), .aluSel(aluSel), .aluData(aluData),
    .writeEn(writeEn), .writeSel(writeSel), .writeData(writeData),
    .writeCount(writeCount),
`ifdef WB_FORWARD_EN
    .fwdValid(fwdValid), .fwdSel(fwdSel), .fwdData(fwdData),
`endif
    .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_write(input wr_t w);
    if (w.sel != '0) begin
      exp_q.push_back(w);
      exp_count++;
    end
  endfunction

  // Reference model: loads are written the cycle they arrive; an accepted ALU
  // result waits behind any load arriving with it or after it, and while one
  // waits no further ALU result is accepted. Register 0 is never written.
  always @(posedge clk) begin
    wr_t m, a;
    bit  alu_acc;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      exp_count = 0;
    end else begin
      m.sel = memSel;  m.data = memData;
      a.sel = aluSel;  a.data = aluData;
      alu_acc = aluValid && (pend_q.size() == 0);
      if (memValid) begin
        expect_write(m);
        if (alu_acc) pend_q.push_back(a);
      end else if (pend_q.size() != 0) begin
        expect_write(pend_q.pop_front());
      end else if (alu_acc) begin
        expect_write(a);
      end
    end
  end

  // Monitor: compares DUT outputs with the model half a cycle after each edge.
  always @(negedge clk) begin
    wr_t e;
    check("memReady", 64'(memReady), 64'(1'b1));
    check("aluReady", 64'(aluReady), 64'(pend_q.size() == 0));
    check("busy", 64'(busy), 64'(pend_q.size() != 0));
    check("writeCount", 64'(writeCount), 64'(exp_count));
    if (writeEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(writeEn), 64'(1'b0));
      end else begin
        e = exp_q.pop_front();
        check("writeSel", 64'(writeSel), 64'(e.sel));
        check("writeData", 64'(writeData), 64'(e.data));
      end
    end else begin
      check("missed_write", 64'(exp_q.size()), 64'd0);
    end
  end

  task automatic cyc(input bit r, input bit mv, input int ms, input logic [XLEN-1:0] md,
                     input bit av, input int as, input logic [XLEN-1:0] ad);
    @(negedge clk);
    rst      = r;
    memValid = mv; memSel = RW'(ms); memData = md;
    aluValid = av; aluSel = RW'(as); aluData = ad;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held for 3 cycles with an ALU result presented.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1, 32'h11);
    cyc(0, 0, 0, 0, 1, 1, 32'h11);
    idle(2);

    // Single ALU result.
    cyc(0, 0, 0, 0, 1, 2, 32'hDEADBEEF);
    idle(2);

    // Collision on the same register: load first, then the ALU result.
    cyc(0, 1, 3, 32'hA5, 1, 3, 32'h5A);
    idle(3);

    // Parked ALU result starved by four back-to-back loads, then drained.
    cyc(0, 1, 2, 32'h01, 1, 1, 32'h77);
    cyc(0, 1, 2, 32'h02, 0, 0, 0);
    cyc(0, 1, 3, 32'h03, 0, 0, 0);
    cyc(0, 1, 2, 32'h04, 0, 0, 0);
    cyc(0, 1, 3, 32'h05, 0, 0, 0);
    idle(3);

    // Register 0 result is consumed but never written.
    cyc(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    idle(2);

    // Reset while a result is parked drops it and clears the count.
    cyc(0, 1, 1, 32'hB1, 1, 2, 32'hC2);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Random traffic; a stalled ALU result stays stable until accepted.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst      = 1'b0;
      memValid = ($urandom_range(0, 99) < 40);
      memSel   = RW'($urandom_range(0, 3));
      memData  = $urandom;
      if (!(aluValid && !aluReady)) begin
        aluValid = ($urandom_range(0, 99) < 60);
        aluSel   = RW'($urandom_range(0, 3));
        aluData  = $urandom;
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
    end

    idle(6);
    check("final_pending", 64'(pend_q.size() + exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
